// File: rtl/firebird7_in_gate1_tessent_tdr_data_ctl_w19.sv
// IJTAG TDR controlling the 19-bit functional/IJTAG data mux.
// A capture/shift/update segment that drives the mux select and data and observes the functional bus.
module firebird7_in_gate1_tessent_tdr_data_ctl_w19 #(
    parameter int unsigned DATA_WIDTH = 19
) (
    input  logic                  ijtag_tck,
    input  logic                  ijtag_reset,
    input  logic                  ijtag_sel,
    input  logic                  ijtag_ce,
    input  logic                  ijtag_se,
    input  logic                  ijtag_ue,
    input  logic                  ijtag_si,
    output logic                  ijtag_so,
    input  logic [DATA_WIDTH-1:0] functional_data_in,
    output logic                  ijtag_select,
    output logic [DATA_WIDTH-1:0] ijtag_data_out,
    output logic                  capture_mode
);

    localparam int unsigned CHAIN_LEN = DATA_WIDTH + 2;

    typedef enum logic [1:0] {
        OP_IDLE    = 2'd0,
        OP_CAPTURE = 2'd1,
        OP_SHIFT   = 2'd2,
        OP_UPDATE  = 2'd3
    } op_t;

    logic [CHAIN_LEN-1:0]  r_shift;
    logic                  r_sel_upd;
    logic                  r_mode_upd;
    logic [DATA_WIDTH-1:0] r_data_upd;

    op_t                   w_op;
    logic [DATA_WIDTH-1:0] w_capture_data;

    // Capture wins over shift, shift wins over update; nothing happens while deselected.
    always_comb begin
        w_op = OP_IDLE;
        if (ijtag_sel) begin
            if (ijtag_ce) begin
                w_op = OP_CAPTURE;
            end else if (ijtag_se) begin
                w_op = OP_SHIFT;
            end else if (ijtag_ue) begin
                w_op = OP_UPDATE;
            end
        end
    end

    always_comb begin
        w_capture_data = r_mode_upd ? r_data_upd : functional_data_in;
    end

    always_ff @(posedge ijtag_tck) begin
        if (!ijtag_reset) begin
            r_shift    <= '0;
            r_sel_upd  <= 1'b0;
            r_mode_upd <= 1'b0;
            r_data_upd <= '0;
        end else begin
            unique case (w_op)
                OP_CAPTURE: r_shift <= {r_sel_upd, r_mode_upd, w_capture_data};
                OP_SHIFT:   r_shift <= {ijtag_si, r_shift[CHAIN_LEN-1:1]};
                OP_UPDATE: begin
                    r_sel_upd  <= r_shift[CHAIN_LEN-1];
                    r_mode_upd <= r_shift[DATA_WIDTH];
                    r_data_upd <= r_shift[DATA_WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

    assign ijtag_so       = r_shift[0];
    assign ijtag_select   = r_sel_upd;
    assign capture_mode   = r_mode_upd;
    assign ijtag_data_out = r_data_upd;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_tdr_data_ctl_w19.sv
// Self-checking bench: directed scan sequences plus random traffic against a queue-based chain model.
module tb_firebird7_in_gate1_tessent_tdr_data_ctl_w19;

    logic        tck;
    logic        rst_n;
    logic        sel, ce, se, ue, si;
    logic        so;
    logic [18:0] fdi;
    logic        select_o;
    logic [18:0] data_o;
    logic        mode_o;

    int unsigned n_pass;
    int unsigned n_checks;

    // Model: q[0] is the bit at scan-out, q[20] the select bit.
    bit          q[$];
    logic        m_sel;
    logic        m_mode;
    logic [18:0] m_data;

    firebird7_in_gate1_tessent_tdr_data_ctl_w19 #(.DATA_WIDTH(19)) dut (
        .ijtag_tck          (tck),
        .ijtag_reset        (rst_n),
        .ijtag_sel          (sel),
        .ijtag_ce           (ce),
        .ijtag_se           (se),
        .ijtag_ue           (ue),
        .ijtag_si           (si),
        .ijtag_so           (so),
        .functional_data_in (fdi),
        .ijtag_select       (select_o),
        .ijtag_data_out     (data_o),
        .capture_mode       (mode_o)
    );

    initial tck = 1'b0;
    always #5 tck = ~tck;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_step();
        logic [18:0] src;
        if (!rst_n) begin
            q = {};
            for (int i = 0; i < 21; i++) q.push_back(1'b0);
            m_sel  = 1'b0;
            m_mode = 1'b0;
            m_data = '0;
        end else if (sel) begin
            if (ce) begin
                src = m_mode ? m_data : fdi;
                q = {};
                for (int i = 0; i < 19; i++) q.push_back(src[i]);
                q.push_back(m_mode);
                q.push_back(m_sel);
            end else if (se) begin
                void'(q.pop_front());
                q.push_back(si);
            end else if (ue) begin
                m_sel  = q[20];
                m_mode = q[19];
                for (int i = 0; i < 19; i++) m_data[i] = q[i];
            end
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".so"},     {31'd0, so},       {31'd0, q[0]});
        check({tag, ".select"}, {31'd0, select_o}, {31'd0, m_sel});
        check({tag, ".mode"},   {31'd0, mode_o},   {31'd0, m_mode});
        check({tag, ".data"},   {13'd0, data_o},   {13'd0, m_data});
    endtask

    task automatic cyc(input string tag);
        @(posedge tck);
        #1;
        model_step();
        check_model(tag);
    endtask

    task automatic idle();
        sel = 1'b1; ce = 1'b0; se = 1'b0; ue = 1'b0; si = 1'b0;
    endtask

    task automatic shift_in(input logic [20:0] w, input string tag);
        for (int i = 0; i < 21; i++) begin
            sel = 1'b1; ce = 1'b0; se = 1'b1; ue = 1'b0; si = w[i];
            cyc(tag);
        end
        idle();
    endtask

    task automatic shift_out(output logic [20:0] w, input string tag);
        for (int i = 0; i < 21; i++) begin
            w[i] = so;
            sel = 1'b1; ce = 1'b0; se = 1'b1; ue = 1'b0; si = 1'b0;
            cyc(tag);
        end
        idle();
    endtask

    logic [20:0] got;
    logic [18:0] data_before;

    initial begin
        n_pass = 0;
        n_checks = 0;
        for (int i = 0; i < 21; i++) q.push_back(1'b0);
        m_sel = 1'b0; m_mode = 1'b0; m_data = '0;
        rst_n = 1'b0; sel = 1'b1; ce = 1'b1; se = 1'b0; ue = 1'b1; si = 1'b1;
        fdi = 19'h7FFFF;

        // 1: reset with enables toggling
        cyc("rst0");
        ce = 1'b0; se = 1'b1; ue = 1'b0;
        cyc("rst1");
        check("rst.select", {31'd0, select_o}, 32'd0);
        check("rst.data",   {13'd0, data_o},   32'd0);
        check("rst.mode",   {31'd0, mode_o},   32'd0);
        check("rst.so",     {31'd0, so},       32'd0);
        rst_n = 1'b1;
        idle();
        cyc("idle");

        // 2: load select=1, mode=0, data=5A5A5
        shift_in({1'b1, 1'b0, 19'h5A5A5}, "load1");
        check("load1.hold_select", {31'd0, select_o}, 32'd0);
        check("load1.hold_data",   {13'd0, data_o},   32'd0);
        ue = 1'b1;
        cyc("upd1");
        idle();
        check("upd1.select", {31'd0, select_o}, 32'd1);
        check("upd1.data",   {13'd0, data_o},   32'h5A5A5);
        check("upd1.mode",   {31'd0, mode_o},   32'd0);

        // 3: functional observe
        fdi = 19'h71234;
        ce = 1'b1;
        cyc("cap2");
        idle();
        check("cap2.so_first", {31'd0, so}, 32'd0);
        shift_out(got, "obs2");
        check("obs2.word", {11'd0, got}, 32'h171234);

        // 4: readback mode
        shift_in({1'b1, 1'b1, 19'h000FF}, "load3");
        ue = 1'b1;
        cyc("upd3");
        idle();
        check("upd3.mode", {31'd0, mode_o}, 32'd1);
        fdi = 19'h7FFFF;
        ce = 1'b1;
        cyc("cap3");
        idle();
        shift_out(got, "rb3");
        check("rb3.word", {11'd0, got}, 32'h1800FF);

        // 5: priority
        shift_in({1'b0, 1'b0, 19'h12345}, "load4");
        data_before = data_o;
        ce = 1'b1; se = 1'b1; ue = 1'b1; si = 1'b1;
        cyc("prio_all");
        check("prio_all.data", {13'd0, data_o}, {13'd0, data_before});
        check("prio_all.so",   {31'd0, so},     32'd1);
        ce = 1'b0; se = 1'b1; ue = 1'b1; si = 1'b0;
        cyc("prio_su");
        check("prio_su.data",   {13'd0, data_o},   {13'd0, data_before});
        check("prio_su.select", {31'd0, select_o}, 32'd1);
        idle();

        // 6a: gating holds the chain
        fdi = 19'h2AAAA;
        shift_in({1'b0, 1'b0, 19'h3C3C3}, "load5");
        sel = 1'b0; se = 1'b1;
        for (int i = 0; i < 10; i++) begin
            si = 1'($urandom);
            ce = 1'($urandom);
            ue = 1'($urandom);
            cyc("gated");
        end
        idle();
        shift_out(got, "gate_out");
        check("gate.word", {11'd0, got}, 32'h03C3C3);

        // 6b: reset mid-shift after select was set
        shift_in({1'b1, 1'b0, 19'h00001}, "load6");
        ue = 1'b1;
        cyc("upd6");
        check("upd6.select", {31'd0, select_o}, 32'd1);
        for (int i = 0; i < 7; i++) begin
            sel = 1'b1; ce = 1'b0; se = 1'b1; ue = 1'b0; si = 1'b1;
            cyc("mid6");
        end
        rst_n = 1'b0;
        cyc("rst6");
        check("rst6.select", {31'd0, select_o}, 32'd0);
        check("rst6.so",     {31'd0, so},       32'd0);
        rst_n = 1'b1;
        idle();

        // random traffic
        for (int n = 0; n < 400; n++) begin
            rst_n = ($urandom_range(99) != 0);
            sel   = ($urandom_range(9) != 0);
            ce    = ($urandom_range(9) == 0);
            se    = ($urandom_range(2) != 0);
            ue    = ($urandom_range(7) == 0);
            si    = 1'($urandom);
            fdi   = 19'($urandom);
            cyc("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
